// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states, counter sizing.
// Optional signed multiply/divide is controlled by ALU_SIGNED_MULDIV_EN.
package alu_pkg;

    localparam int unsigned MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_ADD  = 4'd0;
    localparam logic [MODE_W-1:0] MODE_SUB  = 4'd1;
    localparam logic [MODE_W-1:0] MODE_AND  = 4'd2;
    localparam logic [MODE_W-1:0] MODE_OR   = 4'd3;
    localparam logic [MODE_W-1:0] MODE_XOR  = 4'd4;
    localparam logic [MODE_W-1:0] MODE_EQ   = 4'd5;
    localparam logic [MODE_W-1:0] MODE_GE   = 4'd6;
    localparam logic [MODE_W-1:0] MODE_SHR  = 4'd7;
    localparam logic [MODE_W-1:0] MODE_SHL  = 4'd8;
    localparam logic [MODE_W-1:0] MODE_MUL  = 4'd9;
    localparam logic [MODE_W-1:0] MODE_DIV  = 4'd10;
    localparam logic [MODE_W-1:0] MODE_SMUL = 4'd11;
    localparam logic [MODE_W-1:0] MODE_SDIV = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter must hold values 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_iter_w_if.sv
// Request/result bundle between the execute stage and alu_iter_w.
interface alu_iter_w_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                 valid;
    logic [WIDTH-1:0]     in_A;
    logic [WIDTH-1:0]     in_B;
    logic [MODE_W-1:0]    mode;
    logic                 ready;
    logic                 busy;
    logic                 err;
    logic [2*WIDTH-1:0]   out_data;

    modport master (output valid, in_A, in_B, mode,
                    input  ready, busy, err, out_data);
    modport slave  (input  valid, in_A, in_B, mode,
                    output ready, busy, err, out_data);
endinterface

// File: rtl/alu_iter_core.sv
// Shift-add multiply / restoring divide datapath, one bit per cycle for WIDTH cycles.
// Sign conversion exists only when ALU_SIGNED_MULDIV_EN is defined.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_c,
    input  logic               div_c,
`ifdef ALU_SIGNED_MULDIV_EN
    input  logic               sgn_c,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done_c,
    output logic [2*WIDTH-1:0] res_c
);
    localparam int unsigned CW = cnt_width(WIDTH);

    // acc: product high half / partial remainder; lo: multiplier / dividend->quotient
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, div_q, div_d;
    logic [WIDTH:0]   sum_c, shifted_c, diff_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
`ifdef ALU_SIGNED_MULDIV_EN
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0] quo_c, rem_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            div_q   <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            div_q   <= div_d;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
`endif
        end
    end

    always_comb begin
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        div_d  = div_q;
`ifdef ALU_SIGNED_MULDIV_EN
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        a_mag_c = (sgn_c && a[WIDTH-1]) ? -a : a;
        b_mag_c = (sgn_c && b[WIDTH-1]) ? -b : b;
`else
        a_mag_c = a;
        b_mag_c = b;
`endif
        sum_c     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted_c = {acc_q, lo_q[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, opnd_q};
        done_c    = run_q && (cnt_q == CW'(WIDTH - 1));

        if (start_c) begin
            acc_d  = '0;
            lo_d   = div_c ? a_mag_c : b_mag_c;
            opnd_d = div_c ? b_mag_c : a_mag_c;
            cnt_d  = '0;
            run_d  = 1'b1;
            div_d  = div_c;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_a_d = sgn_c & a[WIDTH-1];
            neg_b_d = sgn_c & b[WIDTH-1];
`endif
        end else if (run_q) begin
            if (div_q) begin
                acc_d = diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], ~diff_c[WIDTH]};
            end else begin
                acc_d = sum_c[WIDTH:1];
                lo_d  = {sum_c[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (done_c) run_d = 1'b0;
        end

        // Result reflects the final iteration so the top can register it on the same edge.
`ifdef ALU_SIGNED_MULDIV_EN
        prod_c = {acc_d, lo_d};
        quo_c  = (neg_a_q ^ neg_b_q) ? -lo_d : lo_d;
        rem_c  = neg_a_q ? -acc_d : acc_d;
        if (div_q) res_c = {rem_c, quo_c};
        else       res_c = (neg_a_q ^ neg_b_q) ? -prod_c : prod_c;
`else
        res_c = {acc_d, lo_d};
`endif
    end

endmodule

// File: rtl/alu_iter_w.sv
// Blocking execute-stage ALU: single-cycle ops plus iterative mul/div, one op in flight.
// Signed multiply/divide (modes 11/12) enabled by defining ALU_SIGNED_MULDIV_EN.
module alu_iter_w
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_iter_w_if.slave  bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e          state_q, state_d;
    logic            ready_q, ready_d, busy_q, busy_d, err_q, err_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    logic            core_start_c, core_div_c, core_done_c;
    logic [DW-1:0]   core_res_c;
    logic [DW-1:0]   sc_res_c;
    logic            sc_err_c, iter_c, iter_div_c;
    logic [WIDTH-1:0] sum_c, diff_c, a_c, b_c;
`ifdef ALU_SIGNED_MULDIV_EN
    logic            iter_sgn_c;
`endif

    assign a_c = bus.in_A;
    assign b_c = bus.in_B;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_c (core_start_c),
        .div_c   (core_div_c),
`ifdef ALU_SIGNED_MULDIV_EN
        .sgn_c   (iter_sgn_c),
`endif
        .a       (a_c),
        .b       (b_c),
        .done_c  (core_done_c),
        .res_c   (core_res_c)
    );

    // Opcode decode: single-cycle result, special cases, iterative dispatch.
    always_comb begin
        sc_res_c   = '0;
        sc_err_c   = 1'b0;
        iter_c     = 1'b0;
        iter_div_c = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
        iter_sgn_c = 1'b0;
`endif
        sum_c  = a_c + b_c;
        diff_c = a_c - b_c;
        case (bus.mode)
            MODE_ADD: begin
                if ((a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_c[WIDTH-1]))
                    sc_res_c = DW'(a_c[WIDTH-1] ? SMIN : SMAX);
                else
                    sc_res_c = DW'(sum_c);
            end
            MODE_SUB: begin
                if ((a_c[WIDTH-1] != b_c[WIDTH-1]) && (diff_c[WIDTH-1] != a_c[WIDTH-1]))
                    sc_res_c = DW'(a_c[WIDTH-1] ? SMIN : SMAX);
                else
                    sc_res_c = DW'(diff_c);
            end
            MODE_AND: sc_res_c = DW'(a_c & b_c);
            MODE_OR:  sc_res_c = DW'(a_c | b_c);
            MODE_XOR: sc_res_c = DW'(a_c ^ b_c);
            MODE_EQ:  sc_res_c = DW'(a_c == b_c);
            MODE_GE:  sc_res_c = DW'($signed(a_c) >= $signed(b_c));
            MODE_SHR: sc_res_c = (b_c >= WIDTH'(WIDTH)) ? '0 : DW'(a_c >> b_c);
            MODE_SHL: sc_res_c = (b_c >= WIDTH'(WIDTH)) ? '0 : DW'(a_c << b_c);
            MODE_MUL: iter_c = 1'b1;
            MODE_DIV: begin
                if (b_c == '0) begin
                    sc_res_c = {a_c, {WIDTH{1'b1}}};
                    sc_err_c = 1'b1;
                end else begin
                    iter_c     = 1'b1;
                    iter_div_c = 1'b1;
                end
            end
`ifdef ALU_SIGNED_MULDIV_EN
            MODE_SMUL: begin
                iter_c     = 1'b1;
                iter_sgn_c = 1'b1;
            end
            MODE_SDIV: begin
                if (b_c == '0) begin
                    sc_res_c = {a_c, {WIDTH{1'b1}}};
                    sc_err_c = 1'b1;
                end else if ((a_c == SMIN) && (b_c == {WIDTH{1'b1}})) begin
                    sc_res_c = DW'(SMIN);
                    sc_err_c = 1'b1;
                end else begin
                    iter_c     = 1'b1;
                    iter_div_c = 1'b1;
                    iter_sgn_c = 1'b1;
                end
            end
`endif
            default: sc_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        err_d        = err_q;
        core_start_c = 1'b0;
        core_div_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    if (iter_c) begin
                        core_start_c = 1'b1;
                        core_div_c   = iter_div_c;
                        state_d      = iter_div_c ? DIV : MUL;
                    end else begin
                        state_d    = DONE;
                        out_data_d = sc_res_c;
                        err_d      = sc_err_c;
                    end
                end
            end
            MUL, DIV: begin
                if (core_done_c) begin
                    state_d    = DONE;
                    out_data_d = core_res_c;
                    err_d      = 1'b0;
                end
            end
            DONE: state_d = IDLE;
        endcase
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.out_data = out_data_q;

endmodule
